ssp_cmd_sequencer: RTL and testbench

- Upstream stage for ssp_uart: converts a queue of register-access commands into SSP frames on the ssp_uart host port.
- Drives SSP_SSEL/SSP_EOC/SSP_RA/SSP_WnR/SSP_DI and captures SSP_DO for reads.
- Returns exactly one response per command, in order, with valid/ready backpressure.
- Replaces hand-driven pin wiggling, so software/bench stimulus becomes command-level.

---
 rtl/ssp_uart_pkg.sv | 39 +++
 rtl/ssp_cmd_fifo.sv | 44 ++++
 rtl/ssp_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_ssp_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_uart_pkg.sv
// Shared types and constants for the ssp_uart host-side command sequencer.
// Holds the register map, the queued command format and the sequencer states.
package ssp_uart_pkg;

  localparam logic [2:0] UCR = 3'd0;
  localparam logic [2:0] USR = 3'd1;
  localparam logic [2:0] RDR = 3'd2;
  localparam logic [2:0] TDR = 3'd3;
  localparam logic [2:0] SPR = 3'd4;

  localparam logic [11:0] UCR_RST      = 12'h000;
  localparam logic [11:0] USR_RST      = 12'h000;
  localparam logic [11:0] RDR_RST      = 12'h000;
  localparam logic [11:0] TDR_RST      = 12'h000;
  localparam logic [11:0] SPR_RST      = 12'h000;
  localparam logic [11:0] SSP_DATA_RST = 12'h000;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wnr;
    logic [11:0] data;
  } ssp_cmd_t;

  localparam int SSP_CMD_W = $bits(ssp_cmd_t);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RWAIT,
    RESP
  } seq_state_e;

  // Address is legal when it lies below the configured register count.
  function automatic logic addr_is_legal(input logic [2:0] addr, input logic [3:0] limit);
    return ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/ssp_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read port.
// Pointers carry one extra bit so full and empty can be told apart.
module ssp_cmd_fifo
  import ssp_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [SSP_CMD_W-1:0] wr_data,
  output logic [SSP_CMD_W-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  ssp_cmd_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ssp_cmd_sequencer.sv
// Turns queued register-access commands into SSP frames for ssp_uart and
// returns one in-order response per command with valid/ready backpressure.
module ssp_cmd_sequencer
  import ssp_uart_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RD_LAT    = 2,
  parameter int NUM_REGS  = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_addr,
  input  logic        cmd_wnr,
  input  logic [11:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_addr,
  output logic        rsp_wnr,
  output logic [11:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        SSP_SSEL,
  output logic        SSP_EOC,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic [11:0] SSP_DI,
  input  logic [11:0] SSP_DO
);

  localparam logic [3:0] REG_LIMIT = 4'(NUM_REGS);
  localparam logic [2:0] LAT_INIT  = 3'(RD_LAT);

  seq_state_e state;
  seq_state_e next_state;
  ssp_cmd_t   cmd_in;
  ssp_cmd_t   head_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       head_legal;
  logic [2:0] lat_cnt;

  assign cmd_in     = '{addr: cmd_addr, wnr: cmd_wnr, data: cmd_data};
  assign cmd_ready  = !fifo_full && !Rst;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign head_legal = addr_is_legal(head_cmd.addr, REG_LIMIT);
  assign busy       = !fifo_empty || (state != IDLE);

  ssp_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .Clk    (Clk),
    .Rst    (Rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_data(cmd_in),
    .rd_data(head_cmd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Illegal addresses skip the SSP frame entirely and answer with an error.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = head_legal ? SETUP : RESP;
        end
      end
      SETUP:   next_state = ACCESS;
      ACCESS:  next_state = rsp_wnr ? RESP : RWAIT;
      RWAIT:   if (lat_cnt == 3'd1) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pins and response fields are registered off the next state so every
  // output changes cleanly on the clock edge that enters a state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      SSP_SSEL  <= 1'b0;
      SSP_EOC   <= 1'b0;
      SSP_RA    <= '0;
      SSP_WnR   <= 1'b0;
      SSP_DI    <= SSP_DATA_RST;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_wnr   <= 1'b0;
      rsp_data  <= SSP_DATA_RST;
      rsp_err   <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      SSP_SSEL  <= (next_state == SETUP) || (next_state == ACCESS) || (next_state == RWAIT);
      SSP_EOC   <= (next_state == ACCESS);
      rsp_valid <= (next_state == RESP);

      if (fifo_pop) begin
        rsp_addr <= head_cmd.addr;
        rsp_wnr  <= head_cmd.wnr;
        rsp_data <= SSP_DATA_RST;
        rsp_err  <= !head_legal;
        if (head_legal) begin
          SSP_RA  <= head_cmd.addr;
          SSP_WnR <= head_cmd.wnr;
          SSP_DI  <= head_cmd.wnr ? head_cmd.data : SSP_DATA_RST;
        end
      end

      if (state == ACCESS) begin
        lat_cnt <= LAT_INIT;
      end else if (state == RWAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          rsp_data <= SSP_DO;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssp_cmd_sequencer.sv
// Randomized self-checking bench: a queue-based command/response model plus a
// small ssp_uart pin model that only presents valid read data on the sample edge.
module tb_ssp_cmd_sequencer;

  localparam int TB_RD_LAT   = 4;
  localparam int TB_NUM_REGS = 5;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wnr;
    logic [11:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wnr;
    logic [11:0] data;
  } frame_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_addr = '0;
  logic        cmd_wnr = 1'b0;
  logic [11:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_addr;
  logic        rsp_wnr;
  logic [11:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        SSP_SSEL;
  logic        SSP_EOC;
  logic [2:0]  SSP_RA;
  logic        SSP_WnR;
  logic [11:0] SSP_DI;
  logic [11:0] SSP_DO = '0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int sampleCycle = 0;
  int readyMode = 0;
  logic [2:0]  sampleAddr = '0;
  logic        sawLow = 1'b1;
  logic [11:0] pinRegs [TB_NUM_REGS] = '{default: 12'h000};
  logic [11:0] shadow  [TB_NUM_REGS] = '{default: 12'h000};
  rsp_t   rspQ [$];
  frame_t frameQ [$];

  ssp_cmd_sequencer #(
    .CMD_DEPTH(4),
    .RD_LAT   (TB_RD_LAT),
    .NUM_REGS (TB_NUM_REGS)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_wnr  (cmd_wnr),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_addr (rsp_addr),
    .rsp_wnr  (rsp_wnr),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .SSP_SSEL (SSP_SSEL),
    .SSP_EOC  (SSP_EOC),
    .SSP_RA   (SSP_RA),
    .SSP_WnR  (SSP_WnR),
    .SSP_DI   (SSP_DI),
    .SSP_DO   (SSP_DO)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle++;

  always @(posedge Clk) begin
    #2;
    case (readyMode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // Command-level expectation: reads return whatever earlier commands wrote.
  function automatic void modelPush(input logic [2:0] a, input logic w, input logic [11:0] d);
    if (int'(a) >= TB_NUM_REGS) begin
      rspQ.push_back('{addr: a, wnr: w, data: 12'h000, err: 1'b1});
    end else if (w) begin
      shadow[a] = d;
      rspQ.push_back('{addr: a, wnr: 1'b1, data: 12'h000, err: 1'b0});
      frameQ.push_back('{addr: a, wnr: 1'b1, data: d});
    end else begin
      rspQ.push_back('{addr: a, wnr: 1'b0, data: shadow[a], err: 1'b0});
      frameQ.push_back('{addr: a, wnr: 1'b0, data: 12'h000});
    end
  endfunction

  always @(negedge Clk) begin
    frame_t f;
    rsp_t   e;
    if (Rst) begin
      rspQ.delete();
      frameQ.delete();
      sampleCycle = 0;
      sawLow      = 1'b1;
      shadow      = pinRegs;
    end else begin
      if (cmd_valid && cmd_ready) modelPush(cmd_addr, cmd_wnr, cmd_data);
      if (!SSP_SSEL) sawLow = 1'b1;
      if (SSP_EOC && !SSP_SSEL) checkOutput("eocWithoutSsel", 32'(SSP_EOC), 32'(SSP_SSEL));
      if (rsp_valid && SSP_SSEL) checkOutput("sselLowInResp", 32'(SSP_SSEL), 32'd0);
      if (SSP_SSEL && SSP_EOC) begin
        if (frameQ.size() == 0) begin
          checkOutput("frameUnexpected", 32'd1, 32'd0);
        end else begin
          f = frameQ.pop_front();
          checkOutput("sselGap", 32'(sawLow), 32'd1);
          checkOutput("frameRa", 32'(SSP_RA), 32'(f.addr));
          checkOutput("frameWnr", 32'(SSP_WnR), 32'(f.wnr));
          checkOutput("frameDi", 32'(SSP_DI), 32'(f.data));
          if (int'(SSP_RA) < TB_NUM_REGS) begin
            if (SSP_WnR) begin
              pinRegs[SSP_RA] = SSP_DI;
            end else begin
              sampleCycle = cycle + 1 + TB_RD_LAT;
              sampleAddr  = SSP_RA;
            end
          end
        end
        sawLow = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        if (rspQ.size() == 0) begin
          checkOutput("rspUnexpected", 32'd1, 32'd0);
        end else begin
          e = rspQ.pop_front();
          checkOutput("rspAddr", 32'(rsp_addr), 32'(e.addr));
          checkOutput("rspWnr", 32'(rsp_wnr), 32'(e.wnr));
          checkOutput("rspData", 32'(rsp_data), 32'(e.data));
          checkOutput("rspErr", 32'(rsp_err), 32'(e.err));
        end
      end
    end
    if (sampleCycle != 0 && cycle + 1 == sampleCycle) SSP_DO = pinRegs[sampleAddr];
    else SSP_DO = ~pinRegs[sampleAddr];
  end

  // Offers one command and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [2:0] a, input logic w, input logic [11:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wnr   = w;
    cmd_data  = d;
    while (!cmd_ready && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 300) checkOutput("cmdAcceptTimeout", 32'd1, 32'd0);
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 500) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 500) checkOutput("idleTimeout", 32'd1, 32'd0);
  endtask

  task automatic timedAccess(input logic [2:0] a, input logic w, input logic [11:0] d, input int expLat);
    int pushEdge;
    int firstSsel = -1;
    int firstEoc = -1;
    int n = 0;
    waitIdle();
    applyStimulus(a, w, d);
    pushEdge = cycle;
    while (!rsp_valid && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (SSP_SSEL && firstSsel < 0) firstSsel = cycle - pushEdge;
      if (SSP_EOC && firstEoc < 0) firstEoc = cycle - pushEdge;
    end
    checkOutput("sselRiseEdge", 32'(firstSsel), 32'd1);
    checkOutput("eocEdge", 32'(firstEoc), 32'd2);
    checkOutput("rspLatency", 32'(cycle - pushEdge), 32'(expLat));
  endtask

  initial begin
    logic [2:0] ra;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("rstSsel", 32'(SSP_SSEL), 32'd0);
    checkOutput("rstEoc", 32'(SSP_EOC), 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRspData", 32'(rsp_data), 32'd0);
    Rst = 1'b0;
    readyMode = 1;
    @(posedge Clk); #1;
    checkOutput("postRstCmdReady", 32'(cmd_ready), 32'd1);
    checkOutput("postRstBusy", 32'(busy), 32'd0);

    for (int i = 0; i < TB_NUM_REGS; i++) applyStimulus(3'(i), 1'b0, 12'hFFF);
    waitIdle();

    timedAccess(UCR_ADDR(), 1'b1, 12'hDED, 3);
    timedAccess(UCR_ADDR(), 1'b0, 12'h000, 3 + TB_RD_LAT);
    timedAccess(3'd3, 1'b0, 12'h000, 3 + TB_RD_LAT);
    waitIdle();

    applyStimulus(3'd5, 1'b0, 12'h000);
    applyStimulus(3'd3, 1'b1, 12'h0A5);
    waitIdle();

    readyMode = 0;
    @(posedge Clk); #1;
    for (int i = 0; i < 5; i++) begin
      ra = 3'($urandom_range(0, 5));
      applyStimulus(ra, 1'($urandom_range(0, 1)), 12'($urandom));
    end
    repeat (8) begin
      @(posedge Clk); #1;
    end
    checkOutput("bpCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("bpBusy", 32'(busy), 32'd1);
    checkOutput("bpRspValid", 32'(rsp_valid), 32'd1);
    readyMode = 1;
    applyStimulus(3'd2, 1'b0, 12'h000);
    waitIdle();

    readyMode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      applyStimulus(ra, 1'($urandom_range(0, 1)), 12'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk); #1;
      end
    end
    readyMode = 1;
    waitIdle();

    applyStimulus(3'd4, 1'b0, 12'h000);
    repeat (4) begin
      @(posedge Clk); #1;
    end
    checkOutput("rwaitSsel", 32'(SSP_SSEL), 32'd1);
    checkOutput("rwaitEoc", 32'(SSP_EOC), 32'd0);
    Rst = 1'b1;
    #1;
    checkOutput("midRstCmdReady", 32'(cmd_ready), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    checkOutput("midRstSsel", 32'(SSP_SSEL), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstRspValid", 32'(rsp_valid), 32'd0);
    @(posedge Clk); #1;
    checkOutput("midRstCmdReadyAfter", 32'(cmd_ready), 32'd1);
    repeat (12) begin
      @(posedge Clk); #1;
    end

    applyStimulus(3'd0, 1'b0, 12'h000);
    waitIdle();
    repeat (2) begin
      @(posedge Clk); #1;
    end
    checkOutput("rspQueueDrained", 32'(rspQ.size()), 32'd0);
    checkOutput("frameQueueDrained", 32'(frameQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [2:0] UCR_ADDR();
    return 3'd0;
  endfunction

endmodule
